// File: rtl/instr_fetch_unit.sv
// Fetch stage for the 16-bit TSC multi-cycle CPU: owns the PC, runs the readM/inputReady
// handshake and holds the instruction for decode. Optional retire counter: NUM_INST_COUNT_EN.
module instr_fetch_unit #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 inputReady,
  output logic [WORD_SIZE-1:0] instr,
  output logic                 instr_valid,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] pc_plus1,
  input  logic                 advance,
  input  logic                 jp,
  input  logic                 jr,
  input  logic [WORD_SIZE-1:0] jr_target,
  input  logic                 branch,
  input  logic                 br_taken
`ifdef NUM_INST_COUNT_EN
  ,
  output logic [WORD_SIZE-1:0] num_inst
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;

  state_e               state_q;
  logic [WORD_SIZE-1:0] next_pc;
  logic [WORD_SIZE-1:0] br_offset;

  assign i_address = pc;
  assign pc_plus1  = pc + WORD_SIZE'(1);

  // Jump beats branch; jr only qualifies jp and br_taken only qualifies branch.
  always_comb begin
    br_offset = {{(WORD_SIZE - 8){instr[7]}}, instr[7:0]};
    next_pc   = pc_plus1;
    if (jp) begin
      next_pc = jr ? jr_target : {pc[WORD_SIZE-1:12], instr[11:0]};
    end else if (branch && br_taken) begin
      next_pc = pc_plus1 + br_offset;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      i_readM     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
          i_readM <= 1'b1;
        end
        StFetch: begin
          if (inputReady) begin
            instr       <= i_data;
            instr_valid <= 1'b1;
            i_readM     <= 1'b0;
            state_q     <= StExec;
          end
        end
        StExec: begin
          if (advance) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            i_readM     <= 1'b1;
            state_q     <= StFetch;
          end
        end
        default: begin
          state_q <= StIdle;
          i_readM <= 1'b0;
        end
      endcase
    end
  end

`ifdef NUM_INST_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_inst <= '0;
    end else if (state_q == StExec && advance) begin
      num_inst <= num_inst + WORD_SIZE'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized control flow
// checked against an arithmetic next-PC model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        inputReady;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        advance;
  logic        jp;
  logic        jr;
  logic [15:0] jr_target;
  logic        branch;
  logic        br_taken;
`ifdef NUM_INST_COUNT_EN
  logic [15:0] num_inst;
  int          exp_count;
`endif

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] exp_pc;
  logic [15:0] exp_instr;

  instr_fetch_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_readM    (i_readM),
    .i_address  (i_address),
    .i_data     (i_data),
    .inputReady (inputReady),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus1   (pc_plus1),
    .advance    (advance),
    .jp         (jp),
    .jr         (jr),
    .jr_target  (jr_target),
    .branch     (branch),
    .br_taken   (br_taken)
`ifdef NUM_INST_COUNT_EN
    ,
    .num_inst   (num_inst)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  // Next PC from the architectural rules, using signed integer arithmetic.
  function automatic logic [15:0] model_next(input logic [15:0] cur_pc, input logic [15:0] ins,
                                             input bit j, input bit r, input logic [15:0] tgt,
                                             input bit b, input bit bt);
    int off;
    int sum;
    if (j && r) return tgt;
    if (j) return (cur_pc & 16'hF000) | (ins & 16'h0FFF);
    if (b && bt) begin
      off = int'(ins & 16'h00FF);
      if (off >= 128) off = off - 256;
      sum = (int'(cur_pc) + 1 + off + 65536) % 65536;
      return 16'(sum);
    end
    return 16'((int'(cur_pc) + 1) % 65536);
  endfunction

  task automatic wait_readM(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i_readM === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_fetch(input logic [15:0] data, input int waits, input bit adv_pulse);
    bit ok;
    wait_readM(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL fetch_req: i_readM=%b required 1", i_readM);
      return;
    end
    tests_run++;
    if (i_address !== exp_pc || pc !== exp_pc) begin
      tests_failed++;
      $display("FAIL fetch_addr: i_address=%h pc=%h required %h", i_address, pc, exp_pc);
    end
    for (int w = 0; w < waits; w++) begin
      advance = adv_pulse && (w == 0);
      i_data  = 16'($urandom);
      @(negedge clk);
      advance = 1'b0;
      tests_run++;
      if (i_readM !== 1'b1 || i_address !== exp_pc || pc !== exp_pc || instr_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL fetch_wait: readM=%b addr=%h pc=%h valid=%b required 1/%h/%h/0",
                 i_readM, i_address, pc, instr_valid, exp_pc, exp_pc);
      end
    end
    i_data     = data;
    inputReady = 1'b1;
    @(negedge clk);
    inputReady = 1'b0;
    i_data     = 16'($urandom);
    exp_instr  = data;
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== data || i_readM !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_done: valid=%b instr=%h readM=%b required 1/%h/0",
               instr_valid, instr, i_readM, data);
    end
  endtask

  task automatic do_exec(input bit j, input bit r, input logic [15:0] tgt, input bit b,
                         input bit bt);
    logic [15:0] nxt;
    logic [15:0] p1;
    nxt = model_next(exp_pc, exp_instr, j, r, tgt, b, bt);
    p1  = exp_pc + 16'd1;
    jp = j; jr = r; jr_target = tgt; branch = b; br_taken = bt;
    advance = 1'b1;
    #1;
    tests_run++;
    if (pc_plus1 !== p1) begin
      tests_failed++;
      $display("FAIL exec_pc_plus1: pc_plus1=%h required %h", pc_plus1, p1);
    end
    @(negedge clk);
    advance = 1'b0; jp = 1'b0; jr = 1'b0; branch = 1'b0; br_taken = 1'b0;
    exp_pc = nxt;
`ifdef NUM_INST_COUNT_EN
    exp_count++;
`endif
    tests_run++;
    if (pc !== nxt || instr_valid !== 1'b0 || i_readM !== 1'b1) begin
      tests_failed++;
      $display("FAIL exec_next: pc=%h valid=%b readM=%b required %h/0/1",
               pc, instr_valid, i_readM, nxt);
    end
  endtask

  task automatic check_pc(input logic [15:0] want);
    tests_run++;
    if (pc !== want) begin
      tests_failed++;
      $display("FAIL directed_pc: pc=%h required %h", pc, want);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; inputReady = 1'b0; i_data = 16'h0; advance = 1'b0;
    jp = 1'b0; jr = 1'b0; jr_target = 16'h0; branch = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (pc !== 16'h0 || instr !== 16'h0 || instr_valid !== 1'b0 || i_readM !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: pc=%h instr=%h valid=%b readM=%b required 0/0/0/0",
               pc, instr, instr_valid, i_readM);
    end
    reset_n = 1'b1;
    exp_pc  = 16'h0;
`ifdef NUM_INST_COUNT_EN
    exp_count = 0;
    tests_run++;
    if (num_inst !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_count: num_inst=%0d required 0", num_inst);
    end
`endif
    @(negedge clk);
    tests_run++;
    if (i_readM !== 1'b1 || i_address !== 16'h0000) begin
      tests_failed++;
      $display("FAIL idle_to_fetch: readM=%b addr=%h required 1/0000", i_readM, i_address);
    end
  endtask

  task automatic test_first_fetch;
    do_fetch(16'h6A05, 0, 1'b0);
  endtask

  task automatic test_sequential;
    do_exec(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check_pc(16'h0001);
    do_fetch(16'h1111, 3, 1'b0);
    do_exec(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check_pc(16'h0002);
    do_fetch(16'h2222, 3, 1'b1);
  endtask

  task automatic test_branch;
    do_exec(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0);
    do_fetch(16'h12FC, 1, 1'b0);
    do_exec(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    check_pc(16'h000D);
    do_fetch(16'h0000, 0, 1'b0);
    do_exec(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0);
    do_fetch(16'h12FC, 0, 1'b0);
    do_exec(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check_pc(16'h0011);
    do_fetch(16'h0000, 0, 1'b0);
  endtask

  task automatic test_jump;
    do_exec(1'b1, 1'b1, 16'h3004, 1'b0, 1'b0);
    do_fetch(16'h9123, 2, 1'b0);
    tests_run++;
    if (pc_plus1 !== 16'h3005) begin
      tests_failed++;
      $display("FAIL jmp_link: pc_plus1=%h required 3005", pc_plus1);
    end
    do_exec(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    check_pc(16'h3123);
    do_fetch(16'h0000, 0, 1'b0);
    do_exec(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    check_pc(16'hBEEF);
    do_fetch(16'h5A5A, 0, 1'b0);
  endtask

  task automatic test_wrap_and_ignores;
    do_exec(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    do_fetch(16'h0123, 2, 1'b1);
    i_data     = 16'hDEAD;
    inputReady = 1'b1;
    @(negedge clk);
    inputReady = 1'b0;
    tests_run++;
    if (instr !== 16'h0123 || instr_valid !== 1'b1 || pc !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL spurious_ready: instr=%h valid=%b pc=%h required 0123/1/ffff",
               instr, instr_valid, pc);
    end
    do_exec(1'b0, 1'b1, 16'h4444, 1'b0, 1'b1);
    check_pc(16'h0000);
    do_fetch(16'h0777, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      do_exec(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      do_fetch(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_fetch;
    bit ok;
    do_exec(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    wait_readM(ok);
    i_data     = 16'hCAFE;
    inputReady = 1'b1;
    reset_n    = 1'b0;
    #1;
    tests_run++;
    if (i_readM !== 1'b0 || instr_valid !== 1'b0 || pc !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_mid_fetch: readM=%b valid=%b pc=%h required 0/0/0000",
               i_readM, instr_valid, pc);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    inputReady = 1'b0;
    exp_pc = 16'h0000;
    tests_run++;
    if (instr !== 16'h0000 || instr_valid !== 1'b0 || i_readM !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_reset: instr=%h valid=%b readM=%b required 0000/0/1",
               instr, instr_valid, i_readM);
    end
`ifdef NUM_INST_COUNT_EN
    exp_count = 0;
    tests_run++;
    if (num_inst !== 16'h0) begin
      tests_failed++;
      $display("FAIL count_reset: num_inst=%0d required 0", num_inst);
    end
`endif
    for (int k = 0; k < 5; k++) begin
      do_fetch(16'($urandom), 1, 1'b1);
      do_exec(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    end
    check_pc(16'h0005);
`ifdef NUM_INST_COUNT_EN
    tests_run++;
    if (num_inst !== 16'(exp_count) || num_inst !== 16'd5) begin
      tests_failed++;
      $display("FAIL count_five: num_inst=%0d required 5", num_inst);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_jump();
    test_wrap_and_ignores();
    test_random();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
